design_mux_sw: RTL and testbench

- Parametrised successor to the single-design IO mux: selects one of NUM_DESIGNS user designs and connects its io_out/io_oeb to the Caravel IO pads.
- Selection is a LA-driven request (sel_clk strobe plus sel_id), synchronised into the wb_clk_i domain.
- Adds break-before-make switching: isolated pads and held design resets for a guard interval; per-design reset outputs; invalid-ID parking; status outputs.
- Sits between all design macros and the user_project_wrapper pad bus.

---
 rtl/design_mux_pkg.sv | 13 +
 rtl/design_mux_sw_if.sv | 29 ++
 rtl/design_mux_sync.sv | 34 +++
 rtl/design_mux_sw.sv | 98 +++++++++
 tb/tb_design_mux_sw.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/design_mux_pkg.sv
// design_mux_pkg: state encoding and default timing constants shared by the design mux slice
package design_mux_pkg;

    typedef enum logic [1:0] {
        ISOLATE = 2'd0,
        RELEASE = 2'd1,
        ACTIVE  = 2'd2
    } mux_state_e;

    localparam int GUARD_CYCLES_DEF = 8;
    localparam int SYNC_STAGES_DEF  = 2;

endpackage

// File: rtl/design_mux_sw_if.sv
// design_mux_sw_if: pad bus between the design macros, the mux and the Caravel IO pads
interface design_mux_sw_if #(
    parameter int NUM_DESIGNS = 4,
    parameter int IO_W        = 38
);

    logic [NUM_DESIGNS*IO_W-1:0] dsn_io_out;
    logic [NUM_DESIGNS*IO_W-1:0] dsn_io_oeb;
    logic [NUM_DESIGNS-1:0]      dsn_rst_n;
    logic [IO_W-1:0]             io_out;
    logic [IO_W-1:0]             io_oeb;

    modport master (
        input  dsn_io_out,
        input  dsn_io_oeb,
        output dsn_rst_n,
        output io_out,
        output io_oeb
    );

    modport slave (
        output dsn_io_out,
        output dsn_io_oeb,
        input  dsn_rst_n,
        input  io_out,
        input  io_oeb
    );

endinterface

// File: rtl/design_mux_sync.sv
// design_mux_sync: STAGES-deep synchroniser giving either the synchronised level or its rising edge
module design_mux_sync
    import design_mux_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF,
    parameter bit EDGE   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;
    logic [STAGES-1:0] fill;
    logic              prev;

    // Shift the input in; the edge flop stays high until the chain holds real samples,
    // so an input already high when reset releases never looks like a fresh edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            fill  <= '0;
            prev  <= 1'b1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            fill  <= {fill[STAGES-2:0], 1'b1};
            prev  <= fill[STAGES-1] ? chain[STAGES-1] : 1'b1;
        end
    end

    assign q = EDGE ? chain[STAGES-1] & ~prev : chain[STAGES-1];

endmodule

// File: rtl/design_mux_sw.sv
// design_mux_sw: break-before-make selector of one of NUM_DESIGNS designs onto the IO pads
// Optional sel_lock input (drops requests while high) under macro DESIGN_MUX_LOCK_EN
module design_mux_sw
    import design_mux_pkg::*;
#(
    parameter int NUM_DESIGNS  = 4,
    parameter int IO_W         = 38,
    parameter int ID_W         = 4,
    parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n,
    input  logic            sel_clk,
    input  logic [ID_W-1:0] sel_id,
`ifdef DESIGN_MUX_LOCK_EN
    input  logic            sel_lock,
`endif
    design_mux_sw_if.master pads,
    output logic [ID_W-1:0] active_id,
    output logic            active_valid,
    output logic            switching
);

    localparam int               CNT_W    = $clog2(GUARD_CYCLES + 1);
    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYCLES - 1);

    mux_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic            sel_rise;
    logic            req;
    logic            id_ok;
    logic            pad_en;
    logic [IO_W-1:0] sel_out;
    logic [IO_W-1:0] sel_oeb;

    design_mux_sync #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_sync_clk (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n),
        .d     (sel_clk),
        .q     (sel_rise)
    );

`ifdef DESIGN_MUX_LOCK_EN
    logic lock_q;

    design_mux_sync #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_sync_lock (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n),
        .d     (sel_lock),
        .q     (lock_q)
    );

    assign req = sel_rise & ~lock_q;
`else
    assign req = sel_rise;
`endif

    // Switch sequencer: a new ID restarts the guard from any state; re-selecting the active ID is a no-op
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= ISOLATE;
            cnt       <= GUARD_LD;
            active_id <= '0;
        end else if (req && !(state == ACTIVE && sel_id == active_id)) begin
            state     <= ISOLATE;
            cnt       <= GUARD_LD;
            active_id <= sel_id;
        end else if (state == ISOLATE) begin
            state <= (cnt == '0) ? RELEASE : ISOLATE;
            cnt   <= (cnt == '0) ? cnt : cnt - 1'b1;
        end else if (state == RELEASE) begin
            state <= ACTIVE;
        end
    end

    // Pick the latched design's slice and release only its reset once isolation is over
    always_comb begin
        sel_out        = '0;
        sel_oeb        = '1;
        pads.dsn_rst_n = '0;
        for (int d = 0; d < NUM_DESIGNS; d++) begin
            if (32'(active_id) == d) begin
                sel_out           = pads.dsn_io_out[d*IO_W +: IO_W];
                sel_oeb           = pads.dsn_io_oeb[d*IO_W +: IO_W];
                pads.dsn_rst_n[d] = (state != ISOLATE);
            end
        end
    end

    assign id_ok        = 32'(active_id) < NUM_DESIGNS;
    assign pad_en       = (state == ACTIVE) && id_ok;
    assign pads.io_out  = pad_en ? sel_out : '0;
    assign pads.io_oeb  = pad_en ? sel_oeb : '1;
    assign active_valid = pad_en;
    assign switching    = (state != ACTIVE);

endmodule

// File: tb/tb_design_mux_sw.sv
// tb_design_mux_sw: directed checks of boot, switching, invalid IDs, guard restart, re-request and mid-switch reset
module tb_design_mux_sw;

    localparam int N   = 4;
    localparam int W   = 38;
    localparam int IDW = 4;

    logic           wb_clk_i = 1'b0;
    logic           wb_rst_n = 1'b0;
    logic           sel_clk  = 1'b0;
    logic [IDW-1:0] sel_id   = '0;
`ifdef DESIGN_MUX_LOCK_EN
    logic           sel_lock = 1'b0;
`endif
    logic [IDW-1:0] active_id;
    logic           active_valid;
    logic           switching;
    logic [W-1:0]   exp_o [N];
    logic [W-1:0]   exp_e [N];
    int             n_run  = 0;
    int             n_fail = 0;

    design_mux_sw_if #(.NUM_DESIGNS(N), .IO_W(W)) pads ();

    design_mux_sw #(
        .NUM_DESIGNS  (N),
        .IO_W         (W),
        .ID_W         (IDW),
        .GUARD_CYCLES (8),
        .SYNC_STAGES  (2)
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_n     (wb_rst_n),
        .sel_clk      (sel_clk),
        .sel_id       (sel_id),
`ifdef DESIGN_MUX_LOCK_EN
        .sel_lock     (sel_lock),
`endif
        .pads         (pads),
        .active_id    (active_id),
        .active_valid (active_valid),
        .switching    (switching)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic apply();
        for (int d = 0; d < N; d++) begin
            pads.dsn_io_out[d*W +: W] = exp_o[d];
            pads.dsn_io_oeb[d*W +: W] = exp_e[d];
        end
    endtask

    task automatic step(int n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // d < 0 means pads must be isolated and active_valid low
    task automatic chk_all(string tag, logic sw, logic [N-1:0] rst, logic [IDW-1:0] id, int d);
        chk({tag, ".switching"}, 64'(switching), 64'(sw));
        chk({tag, ".dsn_rst_n"}, 64'(pads.dsn_rst_n), 64'(rst));
        chk({tag, ".active_id"}, 64'(active_id), 64'(id));
        chk({tag, ".active_valid"}, 64'(active_valid), 64'(d >= 0));
        chk({tag, ".io_out"}, 64'(pads.io_out), d >= 0 ? 64'(exp_o[d]) : 64'd0);
        chk({tag, ".io_oeb"}, 64'(pads.io_oeb), d >= 0 ? 64'(exp_e[d]) : 64'({W{1'b1}}));
    endtask

    initial begin
        for (int d = 0; d < N; d++) begin
            exp_o[d] = {6'(d + 1), 32'hC0DE_0000 + 32'(d)};
            exp_e[d] = {6'(d), 32'h5A5A_0F00 + 32'(d)};
        end
        apply();
        step(1);
        chk_all("reset", 1'b1, 4'b0000, 4'd0, -1);
        wb_rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            chk_all("boot_guard", 1'b1, 4'b0000, 4'd0, -1);
        end
        step(1);
        chk_all("boot_release", 1'b1, 4'b0001, 4'd0, -1);
        step(1);
        chk_all("boot_active", 1'b0, 4'b0001, 4'd0, 0);

        sel_id  = 4'd2;
        sel_clk = 1'b1;
        step(2);
        chk_all("sw2_sync", 1'b0, 4'b0001, 4'd0, 0);
        step(1);
        chk_all("sw2_isolate", 1'b1, 4'b0000, 4'd2, -1);
        sel_clk = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            chk_all("sw2_guard", 1'b1, 4'b0000, 4'd2, -1);
        end
        step(1);
        chk_all("sw2_release", 1'b1, 4'b0100, 4'd2, -1);
        step(1);
        chk_all("sw2_active", 1'b0, 4'b0100, 4'd2, 2);
        exp_o[2] = 38'h15_5555_5555;
        exp_e[2] = 38'h00_0000_FFFF;
        apply();
        #1;
        chk("sw2_live.io_out", 64'(pads.io_out), 64'h15_5555_5555);
        chk("sw2_live.io_oeb", 64'(pads.io_oeb), 64'h00_0000_FFFF);

        sel_id  = 4'd9;
        sel_clk = 1'b1;
        step(3);
        chk_all("inv_isolate", 1'b1, 4'b0000, 4'd9, -1);
        sel_clk = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            chk_all("inv_guard", 1'b1, 4'b0000, 4'd9, -1);
        end
        step(1);
        chk_all("inv_release", 1'b1, 4'b0000, 4'd9, -1);
        step(1);
        chk_all("inv_active", 1'b0, 4'b0000, 4'd9, -1);

        sel_id  = 4'd2;
        sel_clk = 1'b1;
        step(3);
        chk_all("rs_isolate", 1'b1, 4'b0000, 4'd2, -1);
        sel_clk = 1'b0;
        step(1);
        sel_id  = 4'd3;
        sel_clk = 1'b1;
        step(1);
        chk_all("rs_pending", 1'b1, 4'b0000, 4'd2, -1);
        step(1);
        chk_all("rs_pending", 1'b1, 4'b0000, 4'd2, -1);
        step(1);
        chk_all("rs_reload", 1'b1, 4'b0000, 4'd3, -1);
        sel_clk = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            chk_all("rs_guard", 1'b1, 4'b0000, 4'd3, -1);
        end
        step(1);
        chk_all("rs_release", 1'b1, 4'b1000, 4'd3, -1);
        step(1);
        chk_all("rs_active", 1'b0, 4'b1000, 4'd3, 3);

        sel_clk = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk_all("same_id", 1'b0, 4'b1000, 4'd3, 3);
            if (i == 4) sel_clk = 1'b0;
        end

        sel_id  = 4'd1;
        sel_clk = 1'b1;
        step(3);
        chk_all("mr_isolate", 1'b1, 4'b0000, 4'd1, -1);
        sel_clk = 1'b0;
        step(2);
        wb_rst_n = 1'b0;
        #1;
        chk_all("mr_async", 1'b1, 4'b0000, 4'd0, -1);
        sel_clk = 1'b1;
        step(2);
        wb_rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            chk_all("mr_guard", 1'b1, 4'b0000, 4'd0, -1);
        end
        step(1);
        chk_all("mr_release", 1'b1, 4'b0001, 4'd0, -1);
        step(1);
        chk_all("mr_active", 1'b0, 4'b0001, 4'd0, 0);
        step(4);
        chk_all("mr_hold", 1'b0, 4'b0001, 4'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
